io_sequencer: RTL and testbench
===============================

Name: io_sequencer

Overview:
- Sequences user I/O for the CPU `control` block on the board.
- On a CPU input request, it blocks and collects 1 or 2 bytes from `SW[9:2]`. Each byte is confirmed by a debounced KEY press. The assembled word is returned over a four-phase req/ack handshake.
- It also owns the 7-segment output register. The CPU writes that register; during input collection the block overrides the display to show the partial entry.
- Sits between `control` and the top level, driving `block` and `hex_out`.

Parameters:
- DATA_W, 8, width of one switch byte.
- MAX_BYTES, 2, maximum bytes per request. Fixed at 2 in this revision; `rdata` width is DATA_W*MAX_BYTES.

Ports:
- clkin  in  1  system clock (50 MHz), rising-edge.
- reset_n  in  1  asynchronous active-low reset.
- num_in  in  8  switch byte (`SW[9:2]`).
- num_clk  in  1  debounced confirm key, level, active-high.
- req  in  1  CPU input request; level, held until `rvalid` is seen.
- req_len  in  1  0 = 1 byte, 1 = 2 bytes; sampled when `req` is accepted.
- rdata  out  16  assembled input word; stable while `rvalid` = 1.
- rvalid  out  1  ack; high from completion until `req` drops.
- block  out  1  high while waiting for user entry.
- bytes_left  out  2  bytes still to enter (for LEDs).
- out_wr  in  1  CPU display write strobe (one cycle).
- out_data  in  16  CPU display value.
- hex_out  out  32  [15:0] displayed value, [30:16] = 0, [31] = blank.

Behaviour:
- Reset (async, reset_n = 0): IDLE, `rdata` = 0, `rvalid` = 0, `block` = 0, `bytes_left` = 0.
  - Display register = 0 with blank = 1, so `hex_out` = 32'h8000_0000.
  - Key history register = 1, so a key held through reset is never counted.
- Key edge: press = `num_clk` & ~`key_q`; `key_q` <= `num_clk` every cycle in every state.
- FSM states: IDLE, COLLECT, RESPOND.
- IDLE:
  - `req` = 1 -> COLLECT next cycle.
  - Latch len = `req_len` + 1; `acc` <= 0; `bytes_left` <= len; `block` <= 1.
- COLLECT, on press:
  - `acc` <= {`acc`[7:0], `num_in`}; `bytes_left` decrements.
  - If `bytes_left` was 1: `rdata` <= new `acc`, `rvalid` <= 1, `block` <= 0 -> RESPOND.
  - A 1-byte result is zero-extended: `rdata` = {8'h00, byte}.
- COLLECT, `req` = 0 (abort):
  - -> IDLE next cycle; `block` = 0, `bytes_left` = 0, no `rvalid`, `rdata` unchanged.
  - Abort has priority over a press in the same cycle.
- RESPOND:
  - `rvalid` held high until `req` = 0; then `rvalid` <= 0 -> IDLE.
  - A new request needs `req` to fall and rise again (minimum one IDLE cycle).
- Latency: `rvalid` rises 1 cycle after the final press edge. `block` rises 1 cycle after `req`.
- A press while in IDLE or RESPOND is ignored. A key already high on entry to COLLECT needs release and re-press.
- Display register:
  - `out_wr` = 1 loads `out_data` and clears blank, in any state.
  - Simultaneous `out_wr` during COLLECT updates the register; the new value is visible once the override ends.
- hex_out:
  - In COLLECT: {1'b0, 15'd0, `acc`}, which shows the partial entry, 0000 before the first byte.
  - Otherwise: {blank, 15'd0, display register}.
- `rdata` persists after RESPOND until the next completion.

Decomposition:
- Package `io_seq_pkg`:
  - state enum {IDLE, COLLECT, RESPOND};
  - HEX_BLANK_BIT = 31;
  - DATA_W / MAX_BYTES defaults.
- One natural sub-module: `edge_rise`, a registered rising-edge detector with reset value 1, instantiated for `num_clk`.
- Display register and FSM stay in `io_sequencer`.

Test Plan:
- Reset -> `hex_out` = 32'h8000_0000, `block` = 0, `rvalid` = 0. Then `out_wr` with `out_data` = 16'h1234 -> `hex_out` = 32'h0000_1234 next cycle.
- `req` = 1, `req_len` = 1; press with `num_in` = 8'hAB, release, press with 8'hCD:
  - `block` = 1 and `bytes_left` 2 -> 1 -> 0;
  - `hex_out`[15:0] shows 00AB then ABCD;
  - `rvalid` = 1 with `rdata` = 16'hABCD; drop `req` -> `rvalid` = 0 next cycle.
- `req_len` = 0, press with 8'h5F -> `rdata` = 16'h005F. `num_clk` held high for 100 cycles counts once.
- Key held high before and through `req` rise -> no byte taken until release and re-press. Also, a key held through reset is not counted.
- Abort:
  - `req` drops after the first byte -> IDLE, `block` = 0, no `rvalid`, `rdata` keeps its old value.
  - `req` drop coinciding with a press -> abort wins.
- `out_wr` = 16'h0042 during COLLECT -> display shows `acc`; after completion and `req` drop, `hex_out` = 32'h0000_0042.

Source files
------------

// File: rtl/io_seq_pkg.sv
// Shared types and constants for the user I/O sequencer.
package io_seq_pkg;

  localparam int DATA_W        = 8;
  localparam int MAX_BYTES     = 2;
  localparam int HEX_BLANK_BIT = 31;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    RESPOND
  } state_t;

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; history resets high so a level held through reset never fires.
module edge_rise #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_q <= RESET_VAL;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/io_sequencer.sv
// Collects 1-2 switch bytes per CPU request, returns them over req/rvalid, and owns the 7-segment register.
module io_sequencer
  import io_seq_pkg::*;
(
  input  logic        clkin,
  input  logic        reset_n,
  input  logic [7:0]  num_in,
  input  logic        num_clk,
  input  logic        req,
  input  logic        req_len,
  output logic [15:0] rdata,
  output logic        rvalid,
  output logic        block,
  output logic [1:0]  bytes_left,
  input  logic        out_wr,
  input  logic [15:0] out_data,
  output logic [31:0] hex_out
);

  state_t      state, state_n;
  logic [15:0] acc, acc_n;
  logic [15:0] rdata_n;
  logic        rvalid_n, block_n;
  logic [1:0]  bytes_left_n;
  logic [15:0] disp;
  logic        blank;
  logic        press;

  edge_rise #(.RESET_VAL(1'b1)) u_key_edge (
    .clk  (clkin),
    .rst_n(reset_n),
    .d    (num_clk),
    .rise (press)
  );

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_n      = state;
    acc_n        = acc;
    rdata_n      = rdata;
    rvalid_n     = rvalid;
    block_n      = block;
    bytes_left_n = bytes_left;
    unique case (state)
      IDLE: begin
        if (req) begin
          acc_n        = '0;
          bytes_left_n = {1'b0, req_len} + 2'd1;
          block_n      = 1'b1;
          state_n      = COLLECT;
        end
      end
      COLLECT: begin
        // Abort outranks a press arriving in the same cycle.
        if (!req) begin
          block_n      = 1'b0;
          bytes_left_n = '0;
          state_n      = IDLE;
        end else if (press) begin
          acc_n        = {acc[7:0], num_in};
          bytes_left_n = bytes_left - 2'd1;
          if (bytes_left == 2'd1) begin
            rdata_n  = acc_n;
            rvalid_n = 1'b1;
            block_n  = 1'b0;
            state_n  = RESPOND;
          end
        end
      end
      RESPOND: begin
        if (!req) begin
          rvalid_n = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      rdata      <= '0;
      rvalid     <= 1'b0;
      block      <= 1'b0;
      bytes_left <= '0;
    end else begin
      state      <= state_n;
      acc        <= acc_n;
      rdata      <= rdata_n;
      rvalid     <= rvalid_n;
      block      <= block_n;
      bytes_left <= bytes_left_n;
    end
  end

  // The CPU may write the display at any time; the collect override only masks it.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      disp  <= '0;
      blank <= 1'b1;
    end else if (out_wr) begin
      disp  <= out_data;
      blank <= 1'b0;
    end
  end

  always_comb begin
    hex_out = '0;
    if (state == COLLECT) begin
      hex_out[15:0] = acc;
    end else begin
      hex_out[15:0]          = disp;
      hex_out[HEX_BLANK_BIT] = blank;
    end
  end

endmodule

// File: tb/tb_io_sequencer.sv
// Directed bench for io_sequencer: stimulus pushes expected words, a negedge monitor checks each rvalid rise.
module tb_io_sequencer;

  logic        clkin = 1'b0;
  logic        reset_n;
  logic [7:0]  num_in;
  logic        num_clk;
  logic        req;
  logic        req_len;
  logic [15:0] rdata;
  logic        rvalid;
  logic        block;
  logic [1:0]  bytes_left;
  logic        out_wr;
  logic [15:0] out_data;
  logic [31:0] hex_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  logic        rvalid_prev = 1'b0;

  io_sequencer dut (
    .clkin     (clkin),
    .reset_n   (reset_n),
    .num_in    (num_in),
    .num_clk   (num_clk),
    .req       (req),
    .req_len   (req_len),
    .rdata     (rdata),
    .rvalid    (rvalid),
    .block     (block),
    .bytes_left(bytes_left),
    .out_wr    (out_wr),
    .out_data  (out_data),
    .hex_out   (hex_out)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock edge; inputs set after this take effect at the next edge.
  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Monitor: every rvalid rise must match the oldest queued word.
  always @(negedge clkin) begin
    if (reset_n === 1'b1 && rvalid === 1'b1 && rvalid_prev !== 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_rvalid: got rdata %h, expected no response", rdata);
      end else begin
        check("rdata_scoreboard", {16'h0, rdata}, {16'h0, sb.pop_front()});
      end
    end
    rvalid_prev = rvalid;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    num_in   = 8'h00;
    num_clk  = 1'b1;   // key held through reset
    req      = 1'b0;
    req_len  = 1'b0;
    out_wr   = 1'b0;
    out_data = 16'h0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();

    check("reset_hex",        hex_out,             32'h8000_0000);
    check("reset_block",      {31'h0, block},      32'h0);
    check("reset_rvalid",     {31'h0, rvalid},     32'h0);
    check("reset_bytes_left", {30'h0, bytes_left}, 32'h0);
    check("reset_rdata",      {16'h0, rdata},      32'h0);

    out_wr = 1'b1; out_data = 16'h1234;
    tick();
    out_wr = 1'b0;
    check("disp_write", hex_out, 32'h0000_1234);

    // Key still held from reset and through req rise: nothing may be taken.
    req = 1'b1; req_len = 1'b0; num_in = 8'h99;
    tick();
    check("one_byte_block", {31'h0, block},      32'h1);
    check("one_byte_left",  {30'h0, bytes_left}, 32'h1);
    repeat (5) tick();
    check("held_key_ignored", {30'h0, bytes_left}, 32'h1);
    num_clk = 1'b0;
    tick();
    num_in = 8'h5F; num_clk = 1'b1;
    sb.push_back(16'h005F);
    tick();
    check("one_byte_rvalid", {31'h0, rvalid}, 32'h1);
    check("one_byte_rdata",  {16'h0, rdata},  32'h0000_005F);
    check("one_byte_unblock", {31'h0, block}, 32'h0);
    req = 1'b0;
    tick();
    check("one_byte_rvalid_drop", {31'h0, rvalid}, 32'h0);

    // Two-byte entry, first key held for 100 cycles.
    num_clk = 1'b0;
    tick();
    req = 1'b1; req_len = 1'b1;
    tick();
    check("two_byte_block", {31'h0, block},      32'h1);
    check("two_byte_left2", {30'h0, bytes_left}, 32'h2);
    check("two_byte_hex0",  hex_out,             32'h0000_0000);
    num_in = 8'hAB; num_clk = 1'b1;
    tick();
    check("two_byte_left1", {30'h0, bytes_left}, 32'h1);
    check("two_byte_hexAB", hex_out,             32'h0000_00AB);
    repeat (100) tick();
    check("long_hold_once", {30'h0, bytes_left}, 32'h1);
    num_clk = 1'b0;
    tick();
    num_in = 8'hCD; num_clk = 1'b1;
    sb.push_back(16'hABCD);
    tick();
    check("two_byte_rvalid", {31'h0, rvalid},     32'h1);
    check("two_byte_left0",  {30'h0, bytes_left}, 32'h0);
    check("two_byte_rdata",  {16'h0, rdata},      32'h0000_ABCD);
    check("respond_hex",     hex_out,             32'h0000_1234);
    req = 1'b0;
    tick();
    check("two_byte_rvalid_drop", {31'h0, rvalid}, 32'h0);

    // Abort after the first byte.
    num_clk = 1'b0;
    tick();
    req = 1'b1; req_len = 1'b1;
    tick();
    num_in = 8'h11; num_clk = 1'b1;
    tick();
    check("abort_partial_hex", hex_out, 32'h0000_0011);
    num_clk = 1'b0; req = 1'b0;
    tick();
    check("abort_block",  {31'h0, block},      32'h0);
    check("abort_left",   {30'h0, bytes_left}, 32'h0);
    check("abort_rvalid", {31'h0, rvalid},     32'h0);
    check("abort_rdata",  {16'h0, rdata},      32'h0000_ABCD);

    // Abort coinciding with a press: abort wins.
    tick();
    req = 1'b1; req_len = 1'b0;
    tick();
    num_in = 8'h22; num_clk = 1'b1; req = 1'b0;
    tick();
    check("abort_press_block", {31'h0, block},      32'h0);
    check("abort_press_left",  {30'h0, bytes_left}, 32'h0);
    check("abort_press_rdata", {16'h0, rdata},      32'h0000_ABCD);
    check("abort_press_hex",   hex_out,             32'h0000_1234);
    repeat (2) tick();
    check("abort_press_no_rvalid", {31'h0, rvalid}, 32'h0);

    // Display write during collection stays hidden until the override ends.
    num_clk = 1'b0;
    tick();
    req = 1'b1; req_len = 1'b0;
    tick();
    out_wr = 1'b1; out_data = 16'h0042;
    tick();
    out_wr = 1'b0;
    check("collect_override_hex", hex_out, 32'h0000_0000);
    num_in = 8'h77; num_clk = 1'b1;
    sb.push_back(16'h0077);
    tick();
    check("collect_wr_rdata", {16'h0, rdata}, 32'h0000_0077);
    req = 1'b0;
    tick();
    check("post_collect_hex", hex_out, 32'h0000_0042);

    repeat (3) tick();
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
